imem_loader: RTL and testbench

Boot-time program loader for the single-cycle CPU. It receives a framed byte stream over a valid/ready interface, packs bytes big-endian into 32-bit instruction words, and writes them sequentially into instruction memory through its write port. It keeps the CPU held off (`cpu_run_o` low) until a complete frame with a matching checksum has been written. It is the writer side of the instruction-memory interface the CPU fetches from.

---
 rtl/imem_loader_pkg.sv | 28 ++
 rtl/imem_loader_if.sv | 20 ++
 rtl/imem_word_packer.sv | 42 ++++
 rtl/imem_loader.sv | 157 +++++++++++++++
 tb/tb_imem_loader.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the boot-time program loader.
//   - state_t        loader FSM states
//   - BYTE_W/WORD_W  stream byte and instruction word widths
//   - BYTES_PER_WORD bytes packed into one instruction word
//   - word_addr()    byte address of a word index relative to a base
package imem_loader_pkg;

  localparam int BYTE_W         = 8;
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int CNT_W          = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CKSUM,
    S_DONE,
    S_ERR
  } state_t;

  // 32-bit wrap-around is intended: the base may sit near the top of the map.
  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [15:0] idx);
    return base + {14'd0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte stream into the loader.
//   byte_valid_i  source presents a byte
//   byte_data_i   stream byte
//   byte_ready_o  loader can take a byte
// Handshake: a byte transfers on a rising clock edge where byte_valid_i and
// byte_ready_o are both high; neither side may make valid/ready depend
// combinationally on the other. Suffixes name direction as seen by the loader.
//   slave  modport: loader side
//   master modport: byte source side
interface imem_loader_if;
  import imem_loader_pkg::*;

  logic              byte_valid_i;
  logic [BYTE_W-1:0] byte_data_i;
  logic              byte_ready_o;

  modport slave  (input  byte_valid_i, input  byte_data_i, output byte_ready_o);
  modport master (output byte_valid_i, output byte_data_i, input  byte_ready_o);

endinterface

// File: rtl/imem_word_packer.sv
// imem_word_packer: packs stream bytes MSB-first into 32-bit words.
//   clk_i, rst_i   clock, asynchronous active-low reset
//   clr_i          synchronous clear of byte counter and history (frame restart)
//   shift_en_i     a data byte is being accepted this cycle
//   byte_i         the byte being accepted
//   word_o         word completed by byte_i (valid while word_done_o is high)
//   word_done_o    pulse: byte_i is the 4th byte of a word
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              shift_en_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_done_o
);

  logic [CNT_W-1:0] cnt_q;
  // Only the three bytes preceding the current one are ever needed; the
  // fourth is taken straight from byte_i so the top can register the word
  // on the same edge that accepts its last byte.
  logic [WORD_W-BYTE_W-1:0] shift_q;

  assign word_o      = {shift_q, byte_i};
  assign word_done_o = shift_en_i && (cnt_q == CNT_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else if (clr_i) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else if (shift_en_i) begin
      cnt_q   <= cnt_q + CNT_W'(1);
      shift_q <= word_o[WORD_W-BYTE_W-1:0];
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader. Receives a framed byte stream
// (LEN_HI, LEN_LO, 4*N payload bytes, XOR checksum), writes the words into
// instruction memory and releases the CPU only after a good frame.
//   clk_i, rst_i   clock, asynchronous active-low reset
//   bus            byte stream (slave side)
//   restart_i      start a new frame from S_DONE / S_ERR
//   we_o, waddr_o, wdata_o  instruction-memory write port (registered)
//   cpu_run_o      CPU reset release
//   done_o, err_o  frame accepted / frame rejected
//   state_o        current FSM state (debug)
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'd0,
  parameter int          DEPTH     = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  imem_loader_if.slave      bus,
  input  logic              restart_i,
  output logic              we_o,
  output logic [31:0]       waddr_o,
  output logic [WORD_W-1:0] wdata_o,
  output logic              cpu_run_o,
  output logic              done_o,
  output logic              err_o,
  output state_t            state_o
);

  state_t            state_q;
  logic              ready_q;
  logic [BYTE_W-1:0] xor_q;
  logic [15:0]       len_q;
  logic [15:0]       word_idx_q;
  logic              we_q;
  logic [31:0]       waddr_q;
  logic [WORD_W-1:0] wdata_q;
  logic              run_q, done_q, err_q;

  logic              accept;
  logic              shift_en;
  logic              clr;
  logic [15:0]       len_n;
  logic [WORD_W-1:0] word;
  logic              word_done;

  assign accept   = bus.byte_valid_i && ready_q;
  assign shift_en = accept && (state_q == S_DATA);
  assign clr      = restart_i && ((state_q == S_DONE) || (state_q == S_ERR));
  assign len_n    = {len_q[15:8], bus.byte_data_i};

  imem_word_packer u_packer (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clr_i       (clr),
    .shift_en_i  (shift_en),
    .byte_i      (bus.byte_data_i),
    .word_o      (word),
    .word_done_o (word_done)
  );

  // ready_q is kept equal to "state is one of the byte-taking states"; it is
  // written explicitly on every transition into or out of S_DONE / S_ERR.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_LEN_HI;
      ready_q    <= 1'b0;
      xor_q      <= '0;
      len_q      <= '0;
      word_idx_q <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      run_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        S_LEN_HI: begin
          ready_q <= 1'b1;  // first edge after reset raises ready
          if (accept) begin
            len_q[15:8] <= bus.byte_data_i;
            xor_q       <= xor_q ^ bus.byte_data_i;
            state_q     <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (accept) begin
            len_q[7:0] <= bus.byte_data_i;
            xor_q      <= xor_q ^ bus.byte_data_i;
            if ({16'd0, len_n} > 32'(DEPTH)) begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
              ready_q <= 1'b0;
            end else if (len_n == 16'd0) begin
              state_q <= S_CKSUM;
            end else begin
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            xor_q <= xor_q ^ bus.byte_data_i;
            if (word_done) begin
              we_q    <= 1'b1;
              waddr_q <= word_addr(BASE_ADDR, word_idx_q);
              wdata_q <= word;
              if (word_idx_q == len_q - 16'd1) state_q <= S_CKSUM;
              else word_idx_q <= word_idx_q + 16'd1;
            end
          end
        end
        S_CKSUM: begin
          if (accept) begin
            ready_q <= 1'b0;
            if (bus.byte_data_i == xor_q) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              run_q   <= 1'b1;
            end else begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end
          end
        end
        S_DONE, S_ERR: begin
          if (restart_i) begin
            state_q    <= S_LEN_HI;
            ready_q    <= 1'b1;
            xor_q      <= '0;
            len_q      <= '0;
            word_idx_q <= '0;
            run_q      <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
          end
        end
        default: begin
          state_q <= S_LEN_HI;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.byte_ready_o = ready_q;
  assign we_o             = we_q;
  assign waddr_o          = waddr_q;
  assign wdata_o          = wdata_q;
  assign cpu_run_o        = run_q;
  assign done_o           = done_q;
  assign err_o            = err_q;
  assign state_o          = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed bench for imem_loader. Two instances share one
// byte stream: dut0 at BASE_ADDR 0, dut1 at BASE_ADDR 0xFFFFFFFC.
module tb_imem_loader;
  import imem_loader_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic restart;
  always #5 clk = ~clk;

  imem_loader_if if0 ();
  imem_loader_if if1 ();
  assign if1.byte_valid_i = if0.byte_valid_i;
  assign if1.byte_data_i  = if0.byte_data_i;

  logic        we0, run0, done0, err0, we1, run1, done1, err1;
  logic [31:0] waddr0, wdata0, waddr1, wdata1;
  state_t      state0, state1;

  imem_loader #(.BASE_ADDR(32'd0), .DEPTH(256)) dut0 (
    .clk_i(clk), .rst_i(rst_n), .bus(if0.slave), .restart_i(restart),
    .we_o(we0), .waddr_o(waddr0), .wdata_o(wdata0), .cpu_run_o(run0),
    .done_o(done0), .err_o(err0), .state_o(state0)
  );

  imem_loader #(.BASE_ADDR(32'hFFFF_FFFC), .DEPTH(256)) dut1 (
    .clk_i(clk), .rst_i(rst_n), .bus(if1.slave), .restart_i(restart),
    .we_o(we1), .waddr_o(waddr1), .wdata_o(wdata1), .cpu_run_o(run1),
    .done_o(done1), .err_o(err1), .state_o(state1)
  );

  // ---------------- scoreboard ----------------
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp1_q[$];
  logic [63:0] got0_q[$];
  logic [63:0] got1_q[$];
  logic [7:0]  frame_q[$];
  int          dbl_we = 0;
  logic        prev_we0 = 1'b0;

  always @(negedge clk) begin
    if (we0) got0_q.push_back({waddr0, wdata0});
    if (we1) got1_q.push_back({waddr1, wdata1});
    if (we0 && prev_we0) dbl_we++;
    prev_we0 = we0;
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int   gap;
    int   waited;
    logic acc;
    gap = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
    repeat (gap) begin
      if0.byte_valid_i = 1'b0;
      @(posedge clk); #1;
    end
    if0.byte_valid_i = 1'b1;
    if0.byte_data_i  = b;
    waited = 0;
    do begin
      acc = if0.byte_ready_o;
      @(posedge clk); #1;
      waited++;
    end while (!acc && waited < 50);
    if (!acc) begin
      n_cmp++; n_bad++;
      $display("FAIL send_byte_timeout: byte %h got no ready within 50 cycles, required ready", b);
    end
  endtask

  task automatic send_frame(input int max_gap);
    foreach (frame_q[i]) send_byte(frame_q[i], max_gap);
    if0.byte_valid_i = 1'b0;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
  endtask

  task automatic load_basic(input logic [7:0] cksum);
    frame_q = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h0A};
    frame_q.push_back(cksum);
    exp_q  = '{{32'h0000_0000, 32'h2008_0005}, {32'h0000_0004, 32'h2009_000A}};
    exp1_q = '{{32'hFFFF_FFFC, 32'h2008_0005}, {32'h0000_0000, 32'h2009_000A}};
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if ({we0, run0, done0, err0, if0.byte_ready_o} !== 5'b0) begin n_bad++; $display("FAIL reset_flags: got %b required 00000", {we0, run0, done0, err0, if0.byte_ready_o}); end
    n_cmp++; if ({waddr0, wdata0} !== 64'd0) begin n_bad++; $display("FAIL reset_bus: got %h required 0", {waddr0, wdata0}); end
    n_cmp++; if (state0 !== S_LEN_HI) begin n_bad++; $display("FAIL reset_state: got %0d required %0d", state0, S_LEN_HI); end
    rst_n = 1'b1;
    #1;
    n_cmp++; if (if0.byte_ready_o !== 1'b0) begin n_bad++; $display("FAIL ready_before_edge: got %b required 0", if0.byte_ready_o); end
    @(posedge clk); #1;
    n_cmp++; if (if0.byte_ready_o !== 1'b1) begin n_bad++; $display("FAIL ready_after_edge: got %b required 1", if0.byte_ready_o); end
  endtask

  task automatic test_basic();
    got0_q.delete(); got1_q.delete();
    send_byte(8'h00, 0); send_byte(8'h02, 0); send_byte(8'h20, 0);
    send_byte(8'h08, 0); send_byte(8'h00, 0); send_byte(8'h05, 0);
    n_cmp++; if ({we0, waddr0, wdata0} !== {1'b1, 32'h0, 32'h2008_0005}) begin n_bad++; $display("FAIL basic_write0: got we=%b %h/%h required 1 00000000/20080005", we0, waddr0, wdata0); end
    send_byte(8'h20, 0);
    n_cmp++; if (we0 !== 1'b0) begin n_bad++; $display("FAIL basic_we_pulse: got %b required 0", we0); end
    n_cmp++; if (wdata0 !== 32'h2008_0005) begin n_bad++; $display("FAIL basic_wdata_hold: got %h required 20080005", wdata0); end
    send_byte(8'h09, 0); send_byte(8'h00, 0); send_byte(8'h0A, 0);
    n_cmp++; if ({we0, waddr0, wdata0} !== {1'b1, 32'h4, 32'h2009_000A}) begin n_bad++; $display("FAIL basic_write1: got we=%b %h/%h required 1 00000004/2009000A", we0, waddr0, wdata0); end
    n_cmp++; if ({state0, done0} !== {S_CKSUM, 1'b0}) begin n_bad++; $display("FAIL basic_pre_cksum: got state=%0d done=%b required %0d 0", state0, done0, S_CKSUM); end
    send_byte(8'h0C, 0);
    if0.byte_valid_i = 1'b0;
    n_cmp++; if ({done0, run0, err0, if0.byte_ready_o} !== 4'b1100) begin n_bad++; $display("FAIL basic_done: got done/run/err/ready=%b required 1100", {done0, run0, err0, if0.byte_ready_o}); end
    n_cmp++; if (got0_q.size() !== 2) begin n_bad++; $display("FAIL basic_nwrites: got %0d required 2", got0_q.size()); end
    n_cmp++; if (dbl_we !== 0) begin n_bad++; $display("FAIL basic_we_width: got %0d long strobes required 0", dbl_we); end
  endtask

  task automatic test_cksum_err();
    do_restart();
    n_cmp++; if ({state0, done0, run0} !== {S_LEN_HI, 2'b00}) begin n_bad++; $display("FAIL restart_done: got state=%0d done/run=%b required %0d 00", state0, {done0, run0}, S_LEN_HI); end
    got0_q.delete(); got1_q.delete();
    load_basic(8'h0D);
    send_frame(0);
    n_cmp++; if ({err0, run0, done0, if0.byte_ready_o} !== 4'b1000) begin n_bad++; $display("FAIL cksum_err_flags: got err/run/done/ready=%b required 1000", {err0, run0, done0, if0.byte_ready_o}); end
    n_cmp++; if (got0_q.size() !== exp_q.size()) begin n_bad++; $display("FAIL cksum_err_nwrites: got %0d required %0d", got0_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got0_q.size(); i++) begin
      n_cmp++; if (got0_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL cksum_err_write%0d: got %h required %h", i, got0_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_oversize();
    do_restart();
    n_cmp++; if ({state0, err0} !== {S_LEN_HI, 1'b0}) begin n_bad++; $display("FAIL restart_err: got state=%0d err=%b required %0d 0", state0, err0, S_LEN_HI); end
    got0_q.delete(); got1_q.delete();
    send_byte(8'h01, 0);
    n_cmp++; if (err0 !== 1'b0) begin n_bad++; $display("FAIL oversize_early: got err=%b required 0", err0); end
    send_byte(8'h01, 0);
    if0.byte_valid_i = 1'b0;
    n_cmp++; if ({err0, run0, if0.byte_ready_o, state0} !== {3'b100, S_ERR}) begin n_bad++; $display("FAIL oversize_err: got err/run/ready=%b state=%0d required 100 %0d", {err0, run0, if0.byte_ready_o}, state0, S_ERR); end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (got0_q.size() !== 0) begin n_bad++; $display("FAIL oversize_nwrites: got %0d required 0", got0_q.size()); end
  endtask

  task automatic test_zero_len_restart();
    do_restart();
    got0_q.delete(); got1_q.delete();
    frame_q = '{8'h00, 8'h00, 8'h00};
    send_frame(0);
    n_cmp++; if ({done0, run0, err0} !== 3'b110) begin n_bad++; $display("FAIL zero_len_done: got done/run/err=%b required 110", {done0, run0, err0}); end
    n_cmp++; if (got0_q.size() !== 0) begin n_bad++; $display("FAIL zero_len_nwrites: got %0d required 0", got0_q.size()); end
    restart = 1'b1;
    if0.byte_valid_i = 1'b1;
    if0.byte_data_i  = 8'hAA;
    @(posedge clk); #1;
    restart = 1'b0;
    if0.byte_valid_i = 1'b0;
    n_cmp++; if (state0 !== S_LEN_HI) begin n_bad++; $display("FAIL restart_valid_state: got %0d required %0d", state0, S_LEN_HI); end
    n_cmp++; if ({done0, if0.byte_ready_o} !== 2'b01) begin n_bad++; $display("FAIL restart_valid_flags: got done/ready=%b required 01", {done0, if0.byte_ready_o}); end
    send_frame(0);
    n_cmp++; if (done0 !== 1'b1) begin n_bad++; $display("FAIL restart_valid_reload: got done=%b required 1", done0); end
  endtask

  task automatic test_random_valid_wrap();
    do_restart();
    got0_q.delete(); got1_q.delete();
    load_basic(8'h0C);
    send_frame(3);
    n_cmp++; if ({done0, run0, done1, run1} !== 4'b1111) begin n_bad++; $display("FAIL random_done: got %b required 1111", {done0, run0, done1, run1}); end
    n_cmp++; if (got0_q.size() !== 2 || got1_q.size() !== 2) begin n_bad++; $display("FAIL random_nwrites: got %0d/%0d required 2/2", got0_q.size(), got1_q.size()); end
    for (int i = 0; i < 2 && i < got0_q.size(); i++) begin
      n_cmp++; if (got0_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL random_write%0d: got %h required %h", i, got0_q[i], exp_q[i]); end
    end
    for (int i = 0; i < 2 && i < got1_q.size(); i++) begin
      n_cmp++; if (got1_q[i] !== exp1_q[i]) begin n_bad++; $display("FAIL wrap_write%0d: got %h required %h", i, got1_q[i], exp1_q[i]); end
    end
    n_cmp++; if (dbl_we !== 0) begin n_bad++; $display("FAIL random_we_width: got %0d long strobes required 0", dbl_we); end
  endtask

  task automatic test_reset_midframe();
    do_restart();
    frame_q = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h20};
    send_frame(0);
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({we0, run0, done0, err0, if0.byte_ready_o} !== 5'b0) begin n_bad++; $display("FAIL midreset_flags: got %b required 00000", {we0, run0, done0, err0, if0.byte_ready_o}); end
    n_cmp++; if ({waddr0, wdata0} !== 64'd0) begin n_bad++; $display("FAIL midreset_bus: got %h required 0", {waddr0, wdata0}); end
    n_cmp++; if (state0 !== S_LEN_HI) begin n_bad++; $display("FAIL midreset_state: got %0d required %0d", state0, S_LEN_HI); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    got0_q.delete(); got1_q.delete();
    load_basic(8'h0C);
    send_frame(0);
    n_cmp++; if ({done0, run0} !== 2'b11) begin n_bad++; $display("FAIL midreset_reload_done: got %b required 11", {done0, run0}); end
    n_cmp++; if (got0_q.size() !== 2) begin n_bad++; $display("FAIL midreset_nwrites: got %0d required 2", got0_q.size()); end
    for (int i = 0; i < 2 && i < got0_q.size(); i++) begin
      n_cmp++; if (got0_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL midreset_write%0d: got %h required %h", i, got0_q[i], exp_q[i]); end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst_n            = 1'b0;
    restart          = 1'b0;
    if0.byte_valid_i = 1'b0;
    if0.byte_data_i  = 8'h00;
    test_reset();
    test_basic();
    test_cksum_err();
    test_oversize();
    test_zero_len_restart();
    test_random_valid_wrap();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
